// File: rtl/rom_fetch_seq.sv
// rtl/rom_fetch_seq.sv - ROM address sequencer and registered fetch stage with valid/ready output
module rom_fetch_seq #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = {ADDR_W{1'b1}},
  parameter bit                WRAP       = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              cap;
  logic              out_valid_n;

  // State register; reset aborts any sweep and drops a held byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, pointer update and capture decision.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cap         = 1'b0;
    out_valid_n = out_valid;
    case (state)
      S_IDLE, S_DONE: begin
        if (load_en) ptr_n = load_addr;
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (stop) begin
          state_n = S_DRAIN;
        end else if (!out_valid || out_ready) begin
          cap = 1'b1;
          if (ptr == END_ADDR) begin
            ptr_n = START_ADDR;
            if (!WRAP) state_n = S_DRAIN;
          end else begin
            ptr_n = ptr + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid || out_ready) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    // A capture always refills the slot; otherwise an accept empties it.
    if (cap) begin
      out_valid_n = 1'b1;
    end else if (out_ready) begin
      out_valid_n = 1'b0;
    end
  end

  // Pointer and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= START_ADDR;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      out_valid <= out_valid_n;
      if (cap) begin
        out_data <= rom_data;
        out_addr <= ptr;
      end
    end
  end

  assign rom_addr = ptr;
  assign busy     = (state == S_FETCH) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

endmodule
